// File: rtl/psram_access_arbiter_if.sv
// Bundle of requester, controller and status signals around the PSRAM
// access arbiter. The slave view belongs to the arbiter; the master view
// belongs to whatever drives the requesters and models the controller.
interface psram_access_arbiter_if;

  // Frame writer (requester 0)
  logic        write_rq;
  logic        write_ack;
  logic [20:0] write_addr;
  logic        mem_wr_en;
  logic [31:0] write_data;

  // Frame reader (requester 1)
  logic        read_rq;
  logic        read_ack;
  logic [20:0] read_addr;
  logic        mem_rd_en;
  logic [31:0] read_data;
  logic        read_data_valid;

  // PSRAM controller command port
  logic        ctrl_cmd_en;
  logic        ctrl_cmd;
  logic [20:0] ctrl_addr;
  logic [31:0] ctrl_wr_data;
  logic [31:0] ctrl_rd_data;
  logic        ctrl_rd_data_valid;

  // Status
  logic        hold_timeout;

  modport slave (
    input  write_rq, write_addr, mem_wr_en, write_data,
    input  read_rq, read_addr, mem_rd_en,
    input  ctrl_rd_data, ctrl_rd_data_valid,
    output write_ack, read_ack, read_data, read_data_valid,
    output ctrl_cmd_en, ctrl_cmd, ctrl_addr, ctrl_wr_data,
    output hold_timeout
  );

  modport master (
    output write_rq, write_addr, mem_wr_en, write_data,
    output read_rq, read_addr, mem_rd_en,
    output ctrl_rd_data, ctrl_rd_data_valid,
    input  write_ack, read_ack, read_data, read_data_valid,
    input  ctrl_cmd_en, ctrl_cmd, ctrl_addr, ctrl_wr_data,
    input  hold_timeout
  );

endinterface

// File: rtl/psram_access_arbiter.sv
// Shares one PSRAM controller command port between the frame writer and the
// frame reader. One requester owns the port for a whole burst; a fixed idle
// gap separates consecutive grants. Commands from the owner are registered
// onto the controller port, and read data is always registered back to the
// reader, even after its grant has been released.
module psram_access_arbiter #(
  parameter int MEMORY_BURST  = 32,
  parameter int GAP_CYCLES    = 4,
  parameter int MAX_HOLD      = 255,
  parameter int READ_PRIORITY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  psram_access_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2,
    GAP      = 2'd3
  } state_t;

  typedef enum logic {
    GRANTEE_WRITER = 1'b0,
    GRANTEE_READER = 1'b1
  } grantee_t;

  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam bit         READ_WINS  = (READ_PRIORITY != 0);

  // Reject parameter values the counters cannot represent
  if (MEMORY_BURST < 4 || (MEMORY_BURST % 4) != 0) begin : g_bad_burst
    $error("MEMORY_BURST must be a positive multiple of 4");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  state_t      state_q, state_d;
  grantee_t    last_grant_q, last_grant_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  hold_next;
  logic        hold_timeout_q, hold_timeout_d;
  logic        write_ack_q, write_ack_d;
  logic        read_ack_q, read_ack_d;
  logic        ctrl_cmd_en_q, ctrl_cmd_en_d;
  logic        ctrl_cmd_q, ctrl_cmd_d;
  logic [20:0] ctrl_addr_q, ctrl_addr_d;
  logic [31:0] ctrl_wr_data_q, ctrl_wr_data_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_data_valid_q, read_data_valid_d;

  // Arbitration FSM: grant selection, gap timing, hold supervision and acks
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gap_cnt_d      = gap_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    hold_timeout_d = hold_timeout_q;
    hold_next      = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (bus.write_rq && bus.read_rq) begin
          if (READ_WINS || last_grant_q == GRANTEE_WRITER) begin
            state_d = GRANT_RD;
          end else begin
            state_d = GRANT_WR;
          end
        end else if (bus.read_rq) begin
          state_d = GRANT_RD;
        end else if (bus.write_rq) begin
          state_d = GRANT_WR;
        end
        if (state_d != IDLE) begin
          hold_cnt_d = 8'd0;
        end
      end

      GRANT_WR: begin
        hold_cnt_d = hold_next;
        if (hold_next >= HOLD_LIMIT) begin
          hold_timeout_d = 1'b1;
        end
        if (!bus.write_rq) begin
          state_d      = GAP;
          gap_cnt_d    = 4'd0;
          last_grant_d = GRANTEE_WRITER;
        end
      end

      GRANT_RD: begin
        hold_cnt_d = hold_next;
        if (hold_next >= HOLD_LIMIT) begin
          hold_timeout_d = 1'b1;
        end
        if (!bus.read_rq) begin
          state_d      = GAP;
          gap_cnt_d    = 4'd0;
          last_grant_d = GRANTEE_READER;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    write_ack_d = (state_d == GRANT_WR);
    read_ack_d  = (state_d == GRANT_RD);
  end

  // Command pass-through from the current owner plus the read return path
  always_comb begin
    ctrl_cmd_en_d     = 1'b0;
    ctrl_cmd_d        = ctrl_cmd_q;
    ctrl_addr_d       = ctrl_addr_q;
    ctrl_wr_data_d    = ctrl_wr_data_q;
    read_data_d       = bus.ctrl_rd_data;
    read_data_valid_d = bus.ctrl_rd_data_valid;

    unique case (state_q)
      GRANT_WR: begin
        ctrl_cmd_en_d  = bus.mem_wr_en;
        ctrl_cmd_d     = 1'b1;
        ctrl_wr_data_d = bus.write_data;
        if (bus.mem_wr_en) begin
          ctrl_addr_d = bus.write_addr;
        end
      end

      GRANT_RD: begin
        ctrl_cmd_en_d = bus.mem_rd_en;
        ctrl_cmd_d    = 1'b0;
        if (bus.mem_rd_en) begin
          ctrl_addr_d = bus.read_addr;
        end
      end

      default: begin
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      last_grant_q      <= GRANTEE_READER;
      gap_cnt_q         <= 4'd0;
      hold_cnt_q        <= 8'd0;
      hold_timeout_q    <= 1'b0;
      write_ack_q       <= 1'b0;
      read_ack_q        <= 1'b0;
      ctrl_cmd_en_q     <= 1'b0;
      ctrl_cmd_q        <= 1'b0;
      ctrl_addr_q       <= 21'd0;
      ctrl_wr_data_q    <= 32'd0;
      read_data_q       <= 32'd0;
      read_data_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      gap_cnt_q         <= gap_cnt_d;
      hold_cnt_q        <= hold_cnt_d;
      hold_timeout_q    <= hold_timeout_d;
      write_ack_q       <= write_ack_d;
      read_ack_q        <= read_ack_d;
      ctrl_cmd_en_q     <= ctrl_cmd_en_d;
      ctrl_cmd_q        <= ctrl_cmd_d;
      ctrl_addr_q       <= ctrl_addr_d;
      ctrl_wr_data_q    <= ctrl_wr_data_d;
      read_data_q       <= read_data_d;
      read_data_valid_q <= read_data_valid_d;
    end
  end

  assign bus.write_ack       = write_ack_q;
  assign bus.read_ack        = read_ack_q;
  assign bus.ctrl_cmd_en     = ctrl_cmd_en_q;
  assign bus.ctrl_cmd        = ctrl_cmd_q;
  assign bus.ctrl_addr       = ctrl_addr_q;
  assign bus.ctrl_wr_data    = ctrl_wr_data_q;
  assign bus.read_data       = read_data_q;
  assign bus.read_data_valid = read_data_valid_q;
  assign bus.hold_timeout    = hold_timeout_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Self-checking bench for psram_access_arbiter. Instance A uses the default
// parameters (reader priority, MAX_HOLD=255); instance B uses round-robin
// arbitration with MAX_HOLD=10. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, so each check reflects
// the edge that consumed the previously applied inputs.
module tb_psram_access_arbiter;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   total;
  int   bad;

  psram_access_arbiter_if bus_a ();
  psram_access_arbiter_if bus_b ();

  psram_access_arbiter #(
    .MEMORY_BURST (32),
    .GAP_CYCLES   (4),
    .MAX_HOLD     (255),
    .READ_PRIORITY(1)
  ) dut_a (
    .clk    (clk),
    .reset_n(rst_a_n),
    .bus    (bus_a)
  );

  psram_access_arbiter #(
    .MEMORY_BURST (32),
    .GAP_CYCLES   (4),
    .MAX_HOLD     (10),
    .READ_PRIORITY(0)
  ) dut_b (
    .clk    (clk),
    .reset_n(rst_b_n),
    .bus    (bus_b)
  );

  typedef struct {
    logic        wrq, rrq, wen, ren;
    logic [20:0] waddr, raddr;
    logic [31:0] wdata, rdata;
    logic        rvalid;
    logic        e_wack, e_rack, e_cen, e_cmd;
    logic [20:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    logic        e_rvalid, e_tmo;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic wrq, input logic rrq, input logic wen, input logic ren,
    input logic [20:0] waddr, input logic [20:0] raddr,
    input logic [31:0] wdata, input logic [31:0] rdata, input logic rvalid,
    input logic e_wack, input logic e_rack, input logic e_cen, input logic e_cmd,
    input logic [20:0] e_addr, input logic [31:0] e_wdata,
    input logic [31:0] e_rdata, input logic e_rvalid, input logic e_tmo);
    vec_t v;
    v.wrq = wrq;   v.rrq = rrq;   v.wen = wen;   v.ren = ren;
    v.waddr = waddr; v.raddr = raddr;
    v.wdata = wdata; v.rdata = rdata; v.rvalid = rvalid;
    v.e_wack = e_wack; v.e_rack = e_rack; v.e_cen = e_cen; v.e_cmd = e_cmd;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    v.e_rvalid = e_rvalid; v.e_tmo = e_tmo;
    return v;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus_a.write_rq           = v.wrq;
    bus_a.read_rq            = v.rrq;
    bus_a.mem_wr_en          = v.wen;
    bus_a.mem_rd_en          = v.ren;
    bus_a.write_addr         = v.waddr;
    bus_a.read_addr          = v.raddr;
    bus_a.write_data         = v.wdata;
    bus_a.ctrl_rd_data       = v.rdata;
    bus_a.ctrl_rd_data_valid = v.rvalid;
  endtask

  task automatic check_a_all_zero(input string tag);
    checkOutput({tag, " write_ack"},       32'(bus_a.write_ack),       32'd0);
    checkOutput({tag, " read_ack"},        32'(bus_a.read_ack),        32'd0);
    checkOutput({tag, " ctrl_cmd_en"},     32'(bus_a.ctrl_cmd_en),     32'd0);
    checkOutput({tag, " ctrl_cmd"},        32'(bus_a.ctrl_cmd),        32'd0);
    checkOutput({tag, " ctrl_addr"},       32'(bus_a.ctrl_addr),       32'd0);
    checkOutput({tag, " ctrl_wr_data"},    bus_a.ctrl_wr_data,         32'd0);
    checkOutput({tag, " read_data"},       bus_a.read_data,            32'd0);
    checkOutput({tag, " read_data_valid"}, 32'(bus_a.read_data_valid), 32'd0);
    checkOutput({tag, " hold_timeout"},    32'(bus_a.hold_timeout),    32'd0);
  endtask

  // Main sequence
  initial begin
    total = 0;
    bad   = 0;

    // Writer-alone burst on instance A starting from IDLE with cmd=0,
    // addr=0, wr_data=0. Beats A0..A7 follow the strobe; the gap is probed by
    // re-raising write_rq two cycles before the gap ends.
    //           wrq  rrq  wen  ren  waddr        raddr       wdata        rdata          rv   | wack rack cen cmd  addr        wdata         rdata          rv   tmo
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,21'h000010,21'h000000,32'h00000000,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b0,21'h000000,32'h00000000,32'h00000000,1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b1,1'b0,21'h000010,21'h000000,32'h000000A0,32'h00000000,1'b0, 1'b1,1'b0,1'b1,1'b1,21'h000010,32'h000000A0,32'h00000000,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A1,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A1,32'h00000000,1'b0,1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b1,21'h1FFFFF,21'h00BEEF,32'h000000A2,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A2,32'h00000000,1'b0,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A3,32'hDEAD0001,1'b1, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A3,32'hDEAD0001,1'b1,1'b0);
    vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A4,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A4,32'h00000000,1'b0,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A5,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A5,32'h00000000,1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A6,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A6,32'h00000000,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A7,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000A7,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b0,1'b0,21'h1FFFFF,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b1,1'b0,1'b0,1'b1,21'h000010,32'h000000A7,32'h00000000,1'b0,1'b0);
    vecs[15] = mk(1'b0,1'b0,1'b1,1'b0,21'h000222,21'h000000,32'h000000CC,32'h00000000,1'b0, 1'b0,1'b0,1'b1,1'b1,21'h000222,32'h000000CC,32'h00000000,1'b0,1'b0);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,21'h000222,21'h000000,32'h00000033,32'h00000000,1'b0, 1'b0,1'b0,1'b0,1'b1,21'h000222,32'h000000CC,32'h00000000,1'b0,1'b0);

    // Quiet inputs on both instances, both held in reset
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.write_rq = 1'b1; bus_a.read_rq = 1'b1;
    bus_a.mem_wr_en = 1'b0; bus_a.mem_rd_en = 1'b0;
    bus_a.write_addr = '0; bus_a.read_addr = '0; bus_a.write_data = '0;
    bus_a.ctrl_rd_data = 32'hFFFFFFFF; bus_a.ctrl_rd_data_valid = 1'b1;
    bus_b.write_rq = 1'b0; bus_b.read_rq = 1'b0;
    bus_b.mem_wr_en = 1'b0; bus_b.mem_rd_en = 1'b0;
    bus_b.write_addr = '0; bus_b.read_addr = '0; bus_b.write_data = '0;
    bus_b.ctrl_rd_data = '0; bus_b.ctrl_rd_data_valid = 1'b0;
    #1;

    // Reset held three cycles with both requests high: everything stays 0
    for (int r = 0; r < 3; r++) begin
      tick(1);
      check_a_all_zero($sformatf("reset%0d", r));
    end

    // Release: reader wins the simultaneous request one edge later
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    bus_a.ctrl_rd_data = '0;
    bus_a.ctrl_rd_data_valid = 1'b0;
    tick(1);
    checkOutput("first grant read_ack", 32'(bus_a.read_ack), 32'd1);
    checkOutput("first grant write_ack", 32'(bus_a.write_ack), 32'd0);
    bus_a.write_rq = 1'b0;
    bus_a.read_rq  = 1'b0;
    tick(1);
    checkOutput("first release read_ack", 32'(bus_a.read_ack), 32'd0);
    tick(4);

    // Writer-alone table
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick(1);
      checkOutput($sformatf("row%0d write_ack", i),       32'(bus_a.write_ack),       32'(vecs[i].e_wack));
      checkOutput($sformatf("row%0d read_ack", i),        32'(bus_a.read_ack),        32'(vecs[i].e_rack));
      checkOutput($sformatf("row%0d ctrl_cmd_en", i),     32'(bus_a.ctrl_cmd_en),     32'(vecs[i].e_cen));
      checkOutput($sformatf("row%0d ctrl_cmd", i),        32'(bus_a.ctrl_cmd),        32'(vecs[i].e_cmd));
      checkOutput($sformatf("row%0d ctrl_addr", i),       32'(bus_a.ctrl_addr),       32'(vecs[i].e_addr));
      checkOutput($sformatf("row%0d ctrl_wr_data", i),    bus_a.ctrl_wr_data,         vecs[i].e_wdata);
      checkOutput($sformatf("row%0d read_data", i),       bus_a.read_data,            vecs[i].e_rdata);
      checkOutput($sformatf("row%0d read_data_valid", i), 32'(bus_a.read_data_valid), 32'(vecs[i].e_rvalid));
      checkOutput($sformatf("row%0d hold_timeout", i),    32'(bus_a.hold_timeout),    32'(vecs[i].e_tmo));
    end
    bus_a.mem_wr_en = 1'b0;
    tick(3);

    // Reader priority with both requests rising together
    bus_a.write_rq = 1'b1;
    bus_a.read_rq  = 1'b1;
    tick(1);
    checkOutput("prio read_ack", 32'(bus_a.read_ack), 32'd1);
    checkOutput("prio write_ack", 32'(bus_a.write_ack), 32'd0);

    // Writer strobe while the reader owns the port is ignored
    bus_a.mem_wr_en  = 1'b1;
    bus_a.write_addr = 21'h1FFFFF;
    tick(1);
    checkOutput("ungranted ctrl_cmd_en", 32'(bus_a.ctrl_cmd_en), 32'd0);
    checkOutput("ungranted ctrl_cmd", 32'(bus_a.ctrl_cmd), 32'd0);
    checkOutput("ungranted ctrl_addr", 32'(bus_a.ctrl_addr), 32'h222);
    bus_a.mem_wr_en = 1'b0;
    bus_a.mem_rd_en = 1'b1;
    bus_a.read_addr = 21'h01ABCD;
    tick(1);
    checkOutput("read cmd ctrl_cmd_en", 32'(bus_a.ctrl_cmd_en), 32'd1);
    checkOutput("read cmd ctrl_cmd", 32'(bus_a.ctrl_cmd), 32'd0);
    checkOutput("read cmd ctrl_addr", 32'(bus_a.ctrl_addr), 32'h01ABCD);
    bus_a.mem_rd_en = 1'b0;
    bus_a.read_rq   = 1'b0;
    tick(1);
    checkOutput("prio release read_ack", 32'(bus_a.read_ack), 32'd0);
    checkOutput("prio release ctrl_cmd_en", 32'(bus_a.ctrl_cmd_en), 32'd0);
    // Four gap cycles plus the IDLE decision cycle keep the writer waiting
    for (int g = 0; g < 4; g++) begin
      tick(1);
      checkOutput($sformatf("prio gap%0d write_ack", g), 32'(bus_a.write_ack), 32'd0);
    end
    tick(1);
    checkOutput("prio writer grant write_ack", 32'(bus_a.write_ack), 32'd1);
    bus_a.write_rq = 1'b0;
    tick(5);

    // Read data returned three cycles after the reader let go
    bus_a.read_rq = 1'b1;
    tick(1);
    checkOutput("ret grant read_ack", 32'(bus_a.read_ack), 32'd1);
    bus_a.read_rq = 1'b0;
    tick(1);
    checkOutput("ret release read_ack", 32'(bus_a.read_ack), 32'd0);
    tick(2);
    checkOutput("ret idle read_data_valid", 32'(bus_a.read_data_valid), 32'd0);
    bus_a.ctrl_rd_data       = 32'h12345678;
    bus_a.ctrl_rd_data_valid = 1'b1;
    tick(1);
    checkOutput("ret read_data", bus_a.read_data, 32'h12345678);
    checkOutput("ret read_data_valid", 32'(bus_a.read_data_valid), 32'd1);
    bus_a.ctrl_rd_data       = '0;
    bus_a.ctrl_rd_data_valid = 1'b0;
    tick(1);
    checkOutput("ret end read_data_valid", 32'(bus_a.read_data_valid), 32'd0);

    // Reset in the middle of a grant drops ack and command on the same edge
    bus_a.read_rq = 1'b1;
    tick(1);
    checkOutput("midreset grant read_ack", 32'(bus_a.read_ack), 32'd1);
    bus_a.mem_rd_en = 1'b1;
    bus_a.read_addr = 21'h000777;
    rst_a_n = 1'b0;
    tick(1);
    checkOutput("midreset read_ack", 32'(bus_a.read_ack), 32'd0);
    checkOutput("midreset ctrl_cmd_en", 32'(bus_a.ctrl_cmd_en), 32'd0);
    checkOutput("midreset ctrl_addr", 32'(bus_a.ctrl_addr), 32'd0);
    rst_a_n = 1'b1;
    bus_a.mem_rd_en = 1'b0;
    tick(1);
    checkOutput("postreset read_ack", 32'(bus_a.read_ack), 32'd1);
    checkOutput("A hold_timeout", 32'(bus_a.hold_timeout), 32'd0);
    bus_a.read_rq = 1'b0;
    tick(1);

    // Instance B: writer holds the grant past MAX_HOLD=10
    bus_b.write_rq = 1'b1;
    tick(1);
    checkOutput("tmo grant write_ack", 32'(bus_b.write_ack), 32'd1);
    checkOutput("tmo grant hold_timeout", 32'(bus_b.hold_timeout), 32'd0);
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      checkOutput($sformatf("tmo cycle%0d hold_timeout", c), 32'(bus_b.hold_timeout), 32'd0);
    end
    tick(1);
    checkOutput("tmo cycle10 hold_timeout", 32'(bus_b.hold_timeout), 32'd1);
    checkOutput("tmo cycle10 write_ack", 32'(bus_b.write_ack), 32'd1);
    tick(1);
    checkOutput("tmo cycle11 write_ack", 32'(bus_b.write_ack), 32'd1);
    bus_b.write_rq = 1'b0;
    tick(1);
    checkOutput("tmo release write_ack", 32'(bus_b.write_ack), 32'd0);
    checkOutput("tmo release hold_timeout", 32'(bus_b.hold_timeout), 32'd1);
    tick(4);
    checkOutput("tmo sticky hold_timeout", 32'(bus_b.hold_timeout), 32'd1);

    // Round-robin: writer was last, so reader, then writer, then reader
    bus_b.write_rq = 1'b1;
    bus_b.read_rq  = 1'b1;
    tick(1);
    checkOutput("rr1 read_ack", 32'(bus_b.read_ack), 32'd1);
    checkOutput("rr1 write_ack", 32'(bus_b.write_ack), 32'd0);
    bus_b.read_rq = 1'b0;
    tick(1);
    bus_b.read_rq = 1'b1;
    tick(4);
    checkOutput("rr1 gap read_ack", 32'(bus_b.read_ack), 32'd0);
    checkOutput("rr1 gap write_ack", 32'(bus_b.write_ack), 32'd0);
    tick(1);
    checkOutput("rr2 write_ack", 32'(bus_b.write_ack), 32'd1);
    checkOutput("rr2 read_ack", 32'(bus_b.read_ack), 32'd0);
    bus_b.write_rq = 1'b0;
    tick(1);
    bus_b.write_rq = 1'b1;
    tick(4);
    checkOutput("rr2 gap write_ack", 32'(bus_b.write_ack), 32'd0);
    tick(1);
    checkOutput("rr3 read_ack", 32'(bus_b.read_ack), 32'd1);
    checkOutput("rr3 write_ack", 32'(bus_b.write_ack), 32'd0);
    bus_b.write_rq = 1'b0;
    bus_b.read_rq  = 1'b0;

    // Only reset clears the sticky timeout
    rst_b_n = 1'b0;
    tick(1);
    checkOutput("B reset hold_timeout", 32'(bus_b.hold_timeout), 32'd0);
    checkOutput("B reset read_ack", 32'(bus_b.read_ack), 32'd0);
    rst_b_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
